// File: rtl/data_mem_responder.sv
// Word-addressed data memory slave with a valid/ready request/response handshake
// and programmable wait states. Optional address checking: `define DMEM_RESP_ERR_EN.
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] POISON   = 32'hDEAD_BEEF;
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            cap_we, cap_err;
    logic [AW-1:0]   cap_idx;
    logic [31:0]     cap_wdata;

    logic [31:0]     offset;
    logic [AW-1:0]   req_idx;
    logic            req_err;

    logic            hs, enter_resp;
    logic            acc_we, acc_err;
    logic [AW-1:0]   acc_idx;
    logic [31:0]     acc_wdata;

    // Decode the address once, at the request port; only index/error are kept.
    assign offset  = req_addr - BASE_ADDR;
    assign req_idx = offset[AW+1:2];

`ifdef DMEM_RESP_ERR_EN
    assign req_err = (offset[1:0] != 2'b00) || (|offset[31:AW+2]);
`else
    logic unused_offset_bits;
    assign req_err            = 1'b0;
    assign unused_offset_bits = ^{offset[31:AW+2], offset[1:0]};
`endif

    assign hs = req_valid && req_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        cnt <= 4'd0;
        else if (hs)                    cnt <= CNT_INIT;
        else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_we    <= 1'b0;
            cap_err   <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
        end else if (hs) begin
            cap_we    <= req_we;
            cap_err   <= req_err;
            cap_idx   <= req_idx;
            cap_wdata <= req_wdata;
        end
    end

    // With zero wait states the access happens on the handshake edge itself,
    // before the capture registers hold the request.
    assign enter_resp = (state_nxt == RESP) && (state != RESP);
    assign acc_we     = (state == IDLE) ? req_we    : cap_we;
    assign acc_err    = (state == IDLE) ? req_err   : cap_err;
    assign acc_idx    = (state == IDLE) ? req_idx   : cap_idx;
    assign acc_wdata  = (state == IDLE) ? req_wdata : cap_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else if (enter_resp && acc_we && !acc_err) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata <= POISON;
            rsp_err   <= 1'b0;
        end else if (enter_resp) begin
            rsp_rdata <= (acc_we || acc_err) ? POISON : mem[acc_idx];
            rsp_err   <= acc_err;
        end
    end

endmodule
